ir_stream_tx: RTL and testbench
===============================

// Module: ir_stream_tx
// PURPOSE
// - Transmit side of the instruction-load link: drives the decoder's data_in and init_signal.
// - Accepts instruction words on a valid/ready stream and buffers them.
// - Presents each word stable for HOLD_CYCLES clocks, so the decoder's two-stage capture sees l1==l2 and loads it.
// - Forces l1!=l2 between words and during underrun, so no spurious word is ever stable.
// PARAMETERS
// - DATA_WIDTH   `DATA_WIDTH (16)  instruction/bus word width
// - HOLD_CYCLES  3                 clocks each word is driven; must be >= 2
// - INIT_CYCLES  2                 clocks of init_out high with data 0 before the first word
// - FIFO_DEPTH   4                 input buffer entries; power of two
// PORTS
// - clk       in   1           clock
// - rst_n     in   1           synchronous reset, active-low
// - s_valid   in   1           input word valid
// - s_ready   out  1           buffer can accept; equals !fifo_full
// - s_data    in   DATA_WIDTH  instruction word
// - s_last    in   1           marks last word of the burst
// - init_out  out  1           drives the decoder's init_signal
// - data_out  out  DATA_WIDTH  drives the decoder's data_in; registered
// - busy      out  1           high in every state except IDLE
// - done      out  1           one-clock pulse after the last word's hold completes
// BEHAVIOUR
// - Reset: every output is 0, except s_ready which is 1. FIFO is empty, FSM is in IDLE.
// - Reset mid-burst: same values next clock, buffered words are discarded, no done pulse.
// - Push: s_valid && s_ready stores {s_last, s_data}. s_valid with FIFO full is ignored; the source must hold.
// - FSM states: IDLE, INIT, HOLD, SEP, UNDR, FIN. Outputs are registered and change on the clock that enters a state.
// - IDLE: init_out=0, data_out=0. Go to INIT when the FIFO is non-empty.
// - INIT: init_out=1, data_out=0 for INIT_CYCLES clocks. Then pop the head word w and go to HOLD.
// - HOLD: data_out=w for exactly HOLD_CYCLES clocks; a counter counts HOLD_CYCLES-1 down to 0.
//   - At count 0, if w was marked last, go to FIN.
//   - Otherwise go to SEP.
// - SEP: data_out=~w for 1 clock.
//   - If the FIFO is non-empty, pop the next word into w and go to HOLD.
//   - If it is empty, go to UNDR.
// - UNDR: data_out alternates w, ~w, w, ... every clock, never stable for 2 clocks; init_out stays 1.
//   - Exit on the first clock the FIFO is non-empty: pop the word and enter HOLD.
// - FIN: init_out=0, data_out=0, done=1 for 1 clock. Then IDLE; a non-empty FIFO restarts INIT on the next clock.
// - Simultaneous push and pop in the same clock: both happen. A push into an empty FIFO is poppable the following clock.
// - A burst of N words takes INIT_CYCLES + N*HOLD_CYCLES + (N-1) clocks, plus any UNDR time, plus 1 for FIN.
// - Repeated identical words still get the SEP cycle, so the decoder sees a compare mismatch between them.
// STRUCTURE
// - Shared package / define.h: DATA_WIDTH, and FSM state encodings TX_IDLE..TX_FIN (3-bit) as `define constants.
// - Sub-module ir_tx_fifo: synchronous FIFO, DATA_WIDTH+1 wide, FIFO_DEPTH entries.
//   - Ports: push, pop, din, dout, full, empty.
//   - Wrap-around uses a pointer with one extra bit.
// - Top level holds the FSM, the hold counter, the word register w and the output registers.
// TESTING
// - Reset: hold rst_n=0 for 3 clocks -> data_out=0, init_out=0, busy=0, done=0, s_ready=1.
// - Single word 16'h1234 with last=1:
//   - init_out high 2 clocks with data_out=0.
//   - data_out=1234 for 3 clocks.
//   - done pulses once; busy drops on the clock after done.
// - Burst A5A5, A5A5, 0F0F(last):
//   - data_out sequence: A5A5 x3, 5A5A, A5A5 x3, 5A5A, 0F0F x3.
//   - A decoder-model monitor loads exactly three words, in that order.
// - Underrun: push 0001, wait 12 clocks, then push 0002(last):
//   - data_out alternates FFFE/0001 while waiting, never equal on two consecutive clocks.
//   - Then 0002 is held for 3 clocks.
// - Backpressure: push 6 words back-to-back -> s_ready=0 after 4 accepted; all 6 are transmitted in order, none lost.
// - Reset asserted during HOLD of word 2 of 4 -> next clock all outputs are 0, FIFO is empty, no done; a new burst runs normally.

Source files
------------

// File: rtl/ir_stream_tx_pkg.sv
// ---------------------------------------------------------------------------
// ir_stream_tx_pkg
// Shared definitions for the instruction-load transmit link.
//   TX_DATA_WIDTH : instruction / bus word width
//   tx_state_t    : 3-bit FSM state encoding, TX_IDLE..TX_FIN
//   cnt_width()   : counter width able to hold values 0..n-1 (at least 1 bit)
// ---------------------------------------------------------------------------
package ir_stream_tx_pkg;

    localparam int TX_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        TX_IDLE = 3'd0,
        TX_INIT = 3'd1,
        TX_HOLD = 3'd2,
        TX_SEP  = 3'd3,
        TX_UNDR = 3'd4,
        TX_FIN  = 3'd5
    } tx_state_t;

    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ir_stream_tx_fifo.sv
// ---------------------------------------------------------------------------
// ir_tx_fifo
// Synchronous FIFO buffering {last, word} entries for the transmitter.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push, din  : write din when push is high and the FIFO is not full
//   pop, dout  : dout is the head entry (show-ahead); pop advances it
//   full/empty : occupancy flags derived from the read/write pointers
// Pointers carry one extra bit so full and empty can be told apart when
// the address bits are equal.
// ---------------------------------------------------------------------------
module ir_tx_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible once written.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ir_stream_tx.sv
// ---------------------------------------------------------------------------
// ir_stream_tx
// Transmit side of the instruction-load link. Buffers instruction words and
// drives them to the decoder so its two-stage capture (l1 == l2) loads each
// word exactly once, while nothing else on the bus is ever stable.
//   clk, rst_n      : clock, synchronous active-low reset
//   s_valid, s_ready: input stream handshake
//   s_data, s_last  : instruction word and end-of-burst marker
//   init_out        : decoder init_signal (high from INIT until FIN)
//   data_out        : decoder data_in, registered
//   busy            : high in every state except IDLE
//   done            : one-clock pulse in FIN after the last word's hold
//   dbg_state       : current FSM state
//
// Handshake: a word transfers on every rising clk edge where s_valid and
// s_ready are both high. s_ready is !fifo_full and depends only on
// registered state. A source seeing s_ready low must keep s_valid and the
// payload stable until the transfer happens.
// ---------------------------------------------------------------------------
module ir_stream_tx
    import ir_stream_tx_pkg::*;
#(
    parameter int DATA_WIDTH  = TX_DATA_WIDTH,
    parameter int HOLD_CYCLES = 3,
    parameter int INIT_CYCLES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  init_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output tx_state_t             dbg_state
);

    localparam int CNT_W = cnt_width((HOLD_CYCLES > INIT_CYCLES) ? HOLD_CYCLES : INIT_CYCLES);
    localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    tx_state_t             r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_word;
    logic                  r_last;
    logic                  r_init;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_WIDTH:0]   w_dout;

    assign w_push = s_valid && !w_full;

    // The FSM takes the head word at the end of INIT, at the end of every
    // separator, and on the first underrun clock with data available.
    assign w_pop = !w_empty &&
                   (((r_state == TX_INIT) && (r_cnt == '0)) ||
                    (r_state == TX_SEP) ||
                    (r_state == TX_UNDR));

    ir_tx_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({s_last, s_data}),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_word  <= '0;
            r_last  <= 1'b0;
            r_init  <= 1'b0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    if (!w_empty) begin
                        r_state <= TX_INIT;
                        r_cnt   <= INIT_LOAD;
                        r_init  <= 1'b1;
                        r_data  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                TX_INIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_pop) begin
                        r_state <= TX_HOLD;
                        r_cnt   <= HOLD_LOAD;
                        r_word  <= w_dout[DATA_WIDTH-1:0];
                        r_last  <= w_dout[DATA_WIDTH];
                        r_data  <= w_dout[DATA_WIDTH-1:0];
                    end
                end
                TX_HOLD: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_last) begin
                        r_state <= TX_FIN;
                        r_init  <= 1'b0;
                        r_data  <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        // Inverted word breaks l1 == l2 even for repeated words.
                        r_state <= TX_SEP;
                        r_data  <= ~r_word;
                    end
                end
                TX_SEP: begin
                    if (w_pop) begin
                        r_state <= TX_HOLD;
                        r_cnt   <= HOLD_LOAD;
                        r_word  <= w_dout[DATA_WIDTH-1:0];
                        r_last  <= w_dout[DATA_WIDTH];
                        r_data  <= w_dout[DATA_WIDTH-1:0];
                    end else begin
                        // SEP drove ~w, so the underrun toggle starts on w.
                        r_state <= TX_UNDR;
                        r_data  <= r_word;
                    end
                end
                TX_UNDR: begin
                    if (w_pop) begin
                        r_state <= TX_HOLD;
                        r_cnt   <= HOLD_LOAD;
                        r_word  <= w_dout[DATA_WIDTH-1:0];
                        r_last  <= w_dout[DATA_WIDTH];
                        r_data  <= w_dout[DATA_WIDTH-1:0];
                    end else begin
                        r_data <= ~r_data;
                    end
                end
                TX_FIN: begin
                    r_state <= TX_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= TX_IDLE;
                    r_init  <= 1'b0;
                    r_data  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready   = !w_full;
    assign init_out  = r_init;
    assign data_out  = r_data;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ir_stream_tx.sv
// ---------------------------------------------------------------------------
// tb_ir_stream_tx
// Self-checking bench for ir_stream_tx. Accepted words go into exp_q; a
// decoder-model monitor splits the init_out-high window into runs of equal
// data_out values. A run of 2+ clocks is a word the decoder would load and
// must match the head of exp_q and last exactly HOLD clocks; 1-clock runs
// must be w or ~w of the previous word.
// ---------------------------------------------------------------------------
module tb_ir_stream_tx;
    import ir_stream_tx_pkg::*;

    localparam int DW    = 16;
    localparam int HOLD  = 3;
    localparam int INIT  = 2;
    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_last  = 1'b0;
    logic [DW-1:0] s_data  = '0;
    logic          s_ready;
    logic          init_out;
    logic [DW-1:0] data_out;
    logic          busy;
    logic          done;
    tx_state_t     dbg_state;

    always #5 clk = ~clk;

    ir_stream_tx #(
        .DATA_WIDTH  (DW),
        .HOLD_CYCLES (HOLD),
        .INIT_CYCLES (INIT),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .init_out  (init_out),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW:0]   exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- monitor (decoder model) ----------------
    logic          prev_init    = 1'b0;
    logic          prev_done    = 1'b0;
    logic          prev_busy    = 1'b0;
    logic          mon_in_init  = 1'b0;
    logic          pending_last = 1'b0;
    logic [DW-1:0] run_val      = '0;
    logic [DW-1:0] last_w       = '0;
    int            run_len        = 0;
    int            words_seen     = 0;
    int            done_cnt       = 0;
    int            busy_len       = 0;
    int            last_burst_len = 0;

    task automatic close_run();
        logic [DW:0] e;
        if (mon_in_init) begin
            check("init_phase_data", 32'(run_val), 32'h0);
            check("init_phase_len", run_len, INIT);
            mon_in_init = 1'b0;
        end else if (run_len >= 2) begin
            check("word_expected", 32'(exp_q.size() > 0), 32'h1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("word_value", 32'(run_val), 32'(e[DW-1:0]));
                check("word_hold_len", run_len, HOLD);
                pending_last = e[DW];
                last_w       = run_val;
                words_seen++;
            end
        end else begin
            check("short_run_after_last", 32'(pending_last), 32'h0);
            check("short_run_is_w_or_inv",
                  32'((run_val == last_w) || (run_val == ~last_w)), 32'h1);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_init    = 1'b0;
            prev_done    = 1'b0;
            prev_busy    = 1'b0;
            mon_in_init  = 1'b0;
            pending_last = 1'b0;
            run_len      = 0;
            busy_len     = 0;
        end else begin
            if (init_out) begin
                if (!prev_init) begin
                    mon_in_init  = 1'b1;
                    pending_last = 1'b0;
                    run_val      = data_out;
                    run_len      = 1;
                end else if (data_out == run_val) begin
                    run_len++;
                end else begin
                    close_run();
                    run_val = data_out;
                    run_len = 1;
                end
            end else if (prev_init) begin
                close_run();
                check("fin_done", 32'(done), 32'h1);
                check("fin_data_zero", 32'(data_out), 32'h0);
                check("fin_after_last_word", 32'(pending_last), 32'h1);
                pending_last = 1'b0;
            end
            if (done) begin
                done_cnt++;
                check("done_one_clock", 32'(prev_done), 32'h0);
            end
            if (prev_done) check("busy_drop_after_done", 32'(busy), 32'h0);
            if (!busy) check("idle_outputs_zero", 32'({init_out, done, data_out}), 32'h0);
            if (busy) begin
                busy_len++;
            end else if (prev_busy) begin
                last_burst_len = busy_len;
                busy_len       = 0;
            end
            prev_init = init_out;
            prev_done = done;
            prev_busy = busy;
        end
    end

    // ---------------- driver tasks ----------------
    logic          stall_seen       = 1'b0;
    int            acc_cnt          = 0;
    int            acc_before_stall = 0;
    logic [DW-1:0] prev_gen         = '0;

    task automatic send_word(input logic [DW-1:0] d, input logic last);
        logic ok;
        int   guard;
        ok      = 1'b0;
        guard   = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!ok && guard < 200) begin
            @(negedge clk);
            ok = s_ready;
            if (!ok && !stall_seen) begin
                stall_seen       = 1'b1;
                acc_before_stall = acc_cnt;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        check("push_accepted", 32'(ok), 32'h1);
        if (ok) begin
            exp_q.push_back({last, d});
            acc_cnt++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && !busy) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("idle_reached", 32'(guard < 2000), 32'h1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Random words avoid 0 (would merge with INIT zeros) and the previous
    // word and its inverse (would merge with separator/underrun values).
    function automatic logic [DW-1:0] gen_word();
        logic [DW-1:0] w;
        w = DW'($urandom_range(1, 16'hFFFF));
        while (w == prev_gen || w == ~prev_gen) w = DW'($urandom_range(1, 16'hFFFF));
        prev_gen = w;
        return w;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int w0;
        int d0;
        int guard;
        int n_words;
        int n_bursts;
        int gap;

        // Reset held 3 clocks.
        rst_n = 1'b0;
        idle_cycles(3);
        check("reset_data_out", 32'(data_out), 32'h0);
        check("reset_init_out", 32'(init_out), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_s_ready", 32'(s_ready), 32'h1);
        check("reset_state", 32'(dbg_state), 32'(TX_IDLE));
        rst_n = 1'b1;
        idle_cycles(2);

        // Single word with last.
        w0 = words_seen; d0 = done_cnt;
        send_word(16'h1234, 1'b1);
        wait_idle();
        check("single_words", words_seen - w0, 1);
        check("single_done", done_cnt - d0, 1);
        check("single_burst_len", last_burst_len, INIT + HOLD + 1);

        // Repeated word burst still separated.
        w0 = words_seen; d0 = done_cnt;
        send_word(16'hA5A5, 1'b0);
        send_word(16'hA5A5, 1'b0);
        send_word(16'h0F0F, 1'b1);
        wait_idle();
        check("burst3_words", words_seen - w0, 3);
        check("burst3_done", done_cnt - d0, 1);
        check("burst3_len", last_burst_len, INIT + 3 * HOLD + 2 + 1);

        // Underrun between two words.
        w0 = words_seen; d0 = done_cnt;
        send_word(16'h0001, 1'b0);
        idle_cycles(12);
        send_word(16'h0002, 1'b1);
        wait_idle();
        check("undr_words", words_seen - w0, 2);
        check("undr_done", done_cnt - d0, 1);
        check("undr_len_longer", 32'(last_burst_len > INIT + 2 * HOLD + 1 + 1), 32'h1);

        // Backpressure: six back-to-back words into a four-entry buffer.
        w0 = words_seen; d0 = done_cnt;
        stall_seen = 1'b0; acc_cnt = 0; acc_before_stall = 0;
        for (int i = 1; i <= 6; i++) send_word(DW'(16'h1000 + i), (i == 6));
        check("bp_stall_seen", 32'(stall_seen), 32'h1);
        check("bp_full_only_after_depth", 32'(acc_before_stall >= DEPTH), 32'h1);
        wait_idle();
        check("bp_words", words_seen - w0, 6);
        check("bp_done", done_cnt - d0, 1);

        // Reset during the hold of word 2 of 4.
        send_word(16'h1111, 1'b0);
        send_word(16'h2222, 1'b0);
        send_word(16'h3333, 1'b0);
        send_word(16'h4444, 1'b1);
        guard = 0;
        @(negedge clk);
        while (data_out != 16'h2222 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("mid_reset_reached_word2", 32'(guard < 100), 32'h1);
        d0 = done_cnt;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("mid_reset_data_out", 32'(data_out), 32'h0);
        check("mid_reset_init_out", 32'(init_out), 32'h0);
        check("mid_reset_busy", 32'(busy), 32'h0);
        check("mid_reset_done", 32'(done), 32'h0);
        check("mid_reset_s_ready", 32'(s_ready), 32'h1);
        rst_n = 1'b1;
        idle_cycles(6);
        check("mid_reset_fifo_empty", 32'(busy), 32'h0);
        check("mid_reset_no_done", done_cnt - d0, 0);

        // Randomised bursts with random gaps and occasional overlap.
        w0 = words_seen; d0 = done_cnt;
        n_words = 0; n_bursts = 0;
        for (int b = 0; b < 10; b++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 7) == 0) gap = $urandom_range(5, 14);
                else gap = $urandom_range(0, 2);
                idle_cycles(gap);
                send_word(gen_word(), (i == len - 1));
                n_words++;
            end
            n_bursts++;
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();
        check("rand_words", words_seen - w0, n_words);
        check("rand_done", done_cnt - d0, n_bursts);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
